// File: rtl/display_scan_pkg.sv
// display_scan_pkg: constants and the BCD-to-7-segment table shared by the
// clock controller and the display scan stage.
package display_scan_pkg;

   localparam int DIGITS = 4;
   localparam int SEG_W  = 8;
   localparam int DP_BIT = 7;

   typedef logic [SEG_W-1:0] seg_t;

   // All segments dark, decimal point included (1 = lit).
   localparam seg_t BLANK_PAT = 8'h00;

   // Segment patterns for digits 0..9: bit0 = a ... bit6 = g, bit7 = dp.
   localparam seg_t SEG_TABLE [0:9] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
   };

   // Convert one BCD digit to its segment pattern; non-decimal codes go dark.
   function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
      seg_t pat;
      if (bcd <= 4'd9) begin
         pat = SEG_TABLE[bcd];
      end else begin
         pat = BLANK_PAT;
      end
      return pat;
   endfunction

endpackage

// File: rtl/display_scan_scan_timer.sv
// display_scan_scan_timer (scan_timer): free-running digit-slot timer.
// scan_cnt walks 0..SCAN_DIV-1 inside each slot, dig_idx selects the digit,
// blank marks the dead-time cycles at the start of every slot and
// round_done pulses on the last cycle of digit 3's slot.
module display_scan_scan_timer #(
   parameter  int SCAN_DIV = 4096,
   parameter  int BLANK    = 2,
   localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
)(
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] scan_cnt,
   output logic [1:0]       dig_idx,
   output logic             blank,
   output logic             round_done
);

   logic wrap_s;

   // Decode slot wrap, the dead-time window and the end of a full scan round.
   always_comb begin
      wrap_s     = (scan_cnt == CNT_W'(SCAN_DIV - 1));
      blank      = (scan_cnt < CNT_W'(BLANK));
      round_done = wrap_s && (dig_idx == 2'd3);
   end

   // Advance the in-slot counter and step to the next digit on each wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= CNT_W'(0);
         dig_idx  <= 2'd0;
      end else if (wrap_s) begin
         scan_cnt <= CNT_W'(0);
         dig_idx  <= dig_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + CNT_W'(1);
         dig_idx  <= dig_idx;
      end
   end

endmodule

// File: rtl/display_scan.sv
// display_scan: takes 4-byte segment frames from the controller's display
// stream, commits each complete frame atomically to a shadow buffer and
// multiplexes it onto a 4-digit 7-segment display with dead-time blanking.
// Optional feature: define DISPLAY_BLINK_EN to drive digit 1's decimal point
// as a blinking colon instead of taking it from the data.
module display_scan
   import display_scan_pkg::*;
#(
   parameter int SCAN_DIV       = 4096,
   parameter int BLANK          = 2,
   parameter int TIMEOUT        = 65535,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1,
   parameter int BLINK_DIV      = 128
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              control_display_valid,
   input  logic [SEG_W-1:0]  control_display_data,
   output logic              control_display_ready,
   output logic [SEG_W-1:0]  seg,
   output logic [DIGITS-1:0] dig
);

   localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   // XOR masks that turn a "1 = lit/active" value into pin polarity.
   localparam logic [SEG_W-1:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

   // Write side
   logic [1:0]        wr_ptr_r;
   logic [IDLE_W-1:0] idle_cnt_r;
   logic [SEG_W-1:0]  stage_r  [0:2];
   logic [SEG_W-1:0]  shadow_r [0:DIGITS-1];
   logic              accept_s;
   logic              timeout_s;
   logic              commit_s;
   logic [1:0]        slot_s;

   // Scan side
   logic [CNT_W-1:0]  scan_cnt_s;
   logic [1:0]        dig_idx_s;
   logic              blank_s;
   logic              round_done_s;
   logic [SEG_W-1:0]  disp_r;
   logic [SEG_W-1:0]  disp_next_s;
   logic [SEG_W-1:0]  pattern_s;
   logic [SEG_W-1:0]  seg_next_s;
   logic [DIGITS-1:0] dig_next_s;

   display_scan_scan_timer #(
      .SCAN_DIV (SCAN_DIV),
      .BLANK    (BLANK)
   ) u_scan_timer (
      .clk        (clk),
      .reset      (reset),
      .scan_cnt   (scan_cnt_s),
      .dig_idx    (dig_idx_s),
      .blank      (blank_s),
      .round_done (round_done_s)
   );

   // Decode byte acceptance, partial-frame timeout and the target staging slot.
   // A timeout in the same cycle as a byte discards the partial frame first,
   // so that byte becomes slot 0 of a fresh frame.
   always_comb begin
      accept_s  = control_display_valid && control_display_ready;
      timeout_s = (wr_ptr_r != 2'd0) && (idle_cnt_r == IDLE_W'(TIMEOUT));
      if (timeout_s) begin
         slot_s = 2'd0;
      end else begin
         slot_s = wr_ptr_r;
      end
      commit_s  = accept_s && (slot_s == 2'd3);
   end

   // Frame assembly: staging writes, write pointer and idle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= 2'd0;
         idle_cnt_r <= IDLE_W'(0);
         stage_r[0] <= BLANK_PAT;
         stage_r[1] <= BLANK_PAT;
         stage_r[2] <= BLANK_PAT;
      end else if (accept_s) begin
         wr_ptr_r   <= slot_s + 2'd1;
         idle_cnt_r <= IDLE_W'(0);
         case (slot_s)
            2'd0:    stage_r[0] <= control_display_data;
            2'd1:    stage_r[1] <= control_display_data;
            2'd2:    stage_r[2] <= control_display_data;
            default: stage_r[0] <= stage_r[0]; // slot 3 goes straight to shadow
         endcase
      end else if (timeout_s) begin
         wr_ptr_r   <= 2'd0;
         idle_cnt_r <= IDLE_W'(0);
      end else if (wr_ptr_r != 2'd0) begin
         idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end else begin
         idle_cnt_r <= IDLE_W'(0);
      end
   end

   // Shadow buffer: the whole frame lands in one edge when byte 3 arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DIGITS; i++) begin
            shadow_r[i] <= BLANK_PAT;
         end
      end else if (commit_s) begin
         shadow_r[0] <= stage_r[0];
         shadow_r[1] <= stage_r[1];
         shadow_r[2] <= stage_r[2];
         shadow_r[3] <= control_display_data;
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            shadow_r[i] <= shadow_r[i];
         end
      end
   end

`ifdef DISPLAY_BLINK_EN
   localparam int RND_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [RND_W-1:0] round_cnt_r;
   logic             blink_ph_r;

   // Count completed scan rounds and flip the colon phase every BLINK_DIV rounds.
   always_ff @(posedge clk) begin
      if (reset) begin
         round_cnt_r <= RND_W'(0);
         blink_ph_r  <= 1'b0;
      end else if (round_done_s) begin
         if (round_cnt_r == RND_W'(BLINK_DIV - 1)) begin
            round_cnt_r <= RND_W'(0);
            blink_ph_r  <= ~blink_ph_r;
         end else begin
            round_cnt_r <= round_cnt_r + RND_W'(1);
            blink_ph_r  <= blink_ph_r;
         end
      end else begin
         round_cnt_r <= round_cnt_r;
         blink_ph_r  <= blink_ph_r;
      end
   end
`else
   logic blink_unused_s;
   assign blink_unused_s = round_done_s & (BLINK_DIV > 0);
`endif

   // Pick the pattern for the current slot and build the next pin values.
   // disp_r reloads at the slot start, so a commit never alters a digit mid-slot.
   always_comb begin
      if (scan_cnt_s == CNT_W'(0)) begin
         disp_next_s = shadow_r[dig_idx_s];
      end else begin
         disp_next_s = disp_r;
      end
      pattern_s = disp_next_s;
`ifdef DISPLAY_BLINK_EN
      if (dig_idx_s == 2'd1) begin
         pattern_s[DP_BIT] = blink_ph_r;
      end else begin
         pattern_s[DP_BIT] = disp_next_s[DP_BIT];
      end
`endif
      if (blank_s) begin
         seg_next_s = BLANK_PAT;
         dig_next_s = 4'b0000;
      end else begin
         seg_next_s = pattern_s;
         dig_next_s = 4'b0001 << dig_idx_s;
      end
   end

   // Registered pin drive with polarity applied, plus the ready flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg                   <= SEG_OFF;
         dig                   <= DIG_OFF;
         disp_r                <= BLANK_PAT;
         control_display_ready <= 1'b0;
      end else begin
         seg                   <= seg_next_s ^ SEG_OFF;
         dig                   <= dig_next_s ^ DIG_OFF;
         disp_r                <= disp_next_s;
         control_display_ready <= 1'b1;
      end
   end

endmodule
